// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage controller: FSM encoding,
// IF/ID latch contents and default reset/NOP words.
package pc_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_FAULT = 2'b01
    } state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-stage bus: hazard/redirect controls and imem/incrementer inputs in,
// fetch address and IF/ID latch contents out.
interface pc_fetch_ctrl_if;

    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr_in;
    logic [31:0] pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        misalign_exc;

    // The fetch controller itself.
    modport master (
        input  stall, redirect, redirect_pc, pc_plus4, instr_in,
        output pc, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, misalign_exc
    );

    // Surrounding pipeline: hazard unit, branch unit, imem, incrementer, decode.
    modport slave (
        output stall, redirect, redirect_pc, pc_plus4, instr_in,
        input  pc, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, misalign_exc
    );

endinterface

// File: rtl/pc_fetch_ctrl_if_id_reg.sv
// IF/ID pipeline latch: loads a fetched instruction when enabled, or a bubble
// when squashed; bubble-load wins over enable.
module pc_fetch_ctrl_if_id_reg
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    localparam if_id_t BUBBLE = '{pc: '0, pc4: '0, instr: NOP_INSTR, valid: 1'b0};

    // NOTE: the whole latch is reset, not just valid, so downstream never sees X link addresses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= BUBBLE;
        end else if (bubble) begin
            q <= BUBBLE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage controller: holds the PC, picks redirect / hold / sequential next PC,
// and feeds the IF/ID latch; a misaligned redirect parks it in FAULT until reset.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic              clk,
    input  logic              rst,
    pc_fetch_ctrl_if.master   bus
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ifid_en;
    logic        ifid_bubble;
    if_id_t      ifid_d, ifid_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ifid_en     = 1'b0;
        ifid_bubble = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.redirect) begin
                    ifid_bubble = 1'b1;
                    if (is_word_aligned(bus.redirect_pc)) begin
                        pc_d = bus.redirect_pc;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end else if (!bus.stall) begin
                    pc_d    = bus.pc_plus4;
                    ifid_en = 1'b1;
                end
            end
            ST_FAULT: begin
                ifid_bubble = 1'b1;
            end
            default: begin
                state_d     = ST_FAULT;
                ifid_bubble = 1'b1;
            end
        endcase
    end

    assign ifid_d = '{pc: pc_q, pc4: bus.pc_plus4, instr: bus.instr_in, valid: 1'b1};

    pc_fetch_ctrl_if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk    (clk),
        .rst    (rst),
        .en     (ifid_en),
        .bubble (ifid_bubble),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign bus.pc           = pc_q;
    assign bus.if_id_pc     = ifid_q.pc;
    assign bus.if_id_pc4    = ifid_q.pc4;
    assign bus.if_id_instr  = ifid_q.instr;
    assign bus.if_id_valid  = ifid_q.valid;
    // Only a misaligned redirect can reach FAULT, so the state itself is the sticky flag.
    assign bus.misalign_exc = (state_q == ST_FAULT);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus randomized stall/redirect
// traffic, checked against a cycle-level behavioural model of the fetch stage.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl_if bus ();

    pc_fetch_ctrl #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Instruction memory contents: an arbitrary but address-unique word.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign bus.pc_plus4 = bus.pc + 32'd4;
    assign bus.instr_in = imem(bus.pc);

    // Behavioural model of the architectural fetch state.
    logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
    logic        m_valid, m_fault;

    task automatic model_bubble();
        m_ipc   = 32'h0;
        m_ipc4  = 32'h0;
        m_instr = NOP;
        m_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_pc    = RST_PC;
        m_fault = 1'b0;
        model_bubble();
    endtask

    task automatic model_step(input logic st, input logic rd, input logic [31:0] tgt);
        if (m_fault) return;
        if (rd) begin
            model_bubble();
            if (tgt % 4 == 0) m_pc = tgt;
            else              m_fault = 1'b1;
        end else if (!st) begin
            m_ipc   = m_pc;
            m_ipc4  = m_pc + 32'd4;
            m_instr = imem(m_pc);
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},          bus.pc,                  m_pc);
        check({tag, ".if_id_pc"},    bus.if_id_pc,            m_ipc);
        check({tag, ".if_id_pc4"},   bus.if_id_pc4,           m_ipc4);
        check({tag, ".if_id_instr"}, bus.if_id_instr,         m_instr);
        check({tag, ".valid"},       {31'h0, bus.if_id_valid}, {31'h0, m_valid});
        check({tag, ".exc"},         {31'h0, bus.misalign_exc}, {31'h0, m_fault});
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, check on negedge.
    task automatic cycle(input logic st, input logic rd, input logic [31:0] tgt, input string tag);
        bus.stall       = st;
        bus.redirect    = rd;
        bus.redirect_pc = tgt;
        @(posedge clk);
        model_step(st, rd, tgt);
        @(negedge clk);
        check_all(tag);
    endtask

    // Reset asserted between edges; outputs must clear before any clock edge.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        model_reset();
        #1 check_all(tag);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic        st, rd;
        logic [31:0] tgt;

        rst             = 1'b1;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        model_reset();
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // Sequential fetch, then a two-cycle stall at pc=8.
        cycle(1'b0, 1'b0, 32'h0, "seq0");
        cycle(1'b0, 1'b0, 32'h0, "seq1");
        check("seq1.pc_lit", bus.pc, 32'h8);
        check("seq1.ipc_lit", bus.if_id_pc, 32'h4);
        cycle(1'b1, 1'b0, 32'h0, "stall0");
        cycle(1'b1, 1'b0, 32'h0, "stall1");
        check("stall1.instr_lit", bus.if_id_instr, imem(32'h4));
        cycle(1'b0, 1'b0, 32'h0, "resume");
        check("resume.pc_lit", bus.pc, 32'hC);

        // Aligned redirect, then redirect overriding a stall.
        cycle(1'b0, 1'b1, 32'h40, "redir");
        check("redir.pc_lit", bus.pc, 32'h40);
        cycle(1'b0, 1'b0, 32'h0, "redir_next");
        check("redir_next.ipc_lit", bus.if_id_pc, 32'h40);
        cycle(1'b1, 1'b1, 32'h80, "redir_stall");
        cycle(1'b0, 1'b0, 32'h0, "after_rs");

        // Wrap-around at the top of the address space.
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, "to_top");
        cycle(1'b0, 1'b0, 32'h0, "wrap");
        check("wrap.pc_lit", bus.pc, 32'h0);
        check("wrap.ipc4_lit", bus.if_id_pc4, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, "post_wrap");

        // Misaligned redirect: sticky fault, later traffic ignored, reset clears it.
        cycle(1'b0, 1'b1, 32'h42, "misalign");
        check("misalign.exc_lit", {31'h0, bus.misalign_exc}, 32'h1);
        cycle(1'b0, 1'b1, 32'h100, "fault_redir");
        cycle(1'b1, 1'b0, 32'h0, "fault_stall");
        cycle(1'b0, 1'b0, 32'h0, "fault_free");
        async_reset("rst_fault");
        cycle(1'b0, 1'b0, 32'h0, "post_rst_fault");

        // Reset in the middle of a stall.
        cycle(1'b1, 1'b0, 32'h0, "pre_rst_stall");
        async_reset("rst_stall");
        cycle(1'b0, 1'b0, 32'h0, "post_rst_stall");

        // Randomized traffic with periodic resets to escape FAULT.
        for (int i = 0; i < 600; i++) begin
            rd  = ($urandom % 8) == 0;
            st  = ($urandom % 4) == 0;
            tgt = $urandom;
            if (($urandom % 4) != 0) tgt[1:0] = 2'b00;
            cycle(st, rd, tgt, "rand");
            if ((i % 60) == 59) async_reset("rand_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
